// File: rtl/riscv_lsu_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_lsu_v2                                                 |
// | Description : MEM-stage load/store unit with dcache req/ack handshake,     |
// |               CLINT timer decode and LR/SC reservation with timeout.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module riscv_lsu_v2 #(
   parameter int              XLEN          = 64,
   parameter logic [XLEN-1:0] CLINT         = XLEN'('h2000000),
   parameter int              NUM_HARTS     = 1,
   parameter int              RSV_GRAN_LOG2 = 3,
   parameter int              RSV_TIMEOUT   = 255,
   parameter int              CNT_W         = 8,
   localparam int             RSEL_W        = $clog2(NUM_HARTS + 1) + 1
) (
   input  logic              i_riscv_lsu_clk,
   input  logic              i_riscv_lsu_rst,
   input  logic              i_riscv_lsu_globstall,
   input  logic              i_riscv_lsu_valid,
   input  logic [XLEN-1:0]   i_riscv_lsu_address,
   input  logic [XLEN-1:0]   i_riscv_lsu_alu_result,
   input  logic [1:0]        i_riscv_lsu_lr,
   input  logic [1:0]        i_riscv_lsu_sc,
   input  logic              i_riscv_lsu_amo,
   input  logic              i_riscv_lsu_dcache_rden,
   input  logic              i_riscv_lsu_dcache_wren,
   input  logic              i_riscv_lsu_goto_trap,
   input  logic [1:0]        i_riscv_lsu_return_trap,
   input  logic              i_riscv_lsu_dcache_ack,
   output logic              o_riscv_lsu_dcache_rden,
   output logic              o_riscv_lsu_dcache_wren,
   output logic [XLEN-1:0]   o_riscv_lsu_phy_address,
   output logic [XLEN-1:0]   o_riscv_lsu_sc_rdvalue,
   output logic              o_riscv_lsu_timer_rden,
   output logic              o_riscv_lsu_timer_wren,
   output logic [RSEL_W-1:0] o_riscv_lsu_timer_regsel,
   output logic              o_riscv_lsu_busy,
   output logic              o_riscv_lsu_reserv_valid
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   state_e                    state_q;
   logic [XLEN-1:0]           addr_q;
   logic                      rd_q;
   logic                      wr_q;
   logic                      rsv_valid_q, rsv_valid_d;
   logic                      rsv_word_q, rsv_word_d;
   logic [XLEN-1:RSV_GRAN_LOG2] rsv_gran_q, rsv_gran_d;
   logic [CNT_W-1:0]          rsv_cnt_q, rsv_cnt_d;

   logic                      w_kill, w_go, w_multi;
   logic                      w_op_rd, w_op_wr, w_op_lr, w_op_sc, w_op_amo;
   logic [XLEN-1:0]           w_addr;
   logic [NUM_HARTS-1:0]      w_cmp_hit;
   logic [RSEL_W-1:0]         w_regsel;
   logic                      w_timer_hit;
   logic                      w_sc_ok, w_sc_fail;
   logic                      w_idle_rd, w_idle_wr, w_store_hit;

   assign w_kill  = i_riscv_lsu_goto_trap | (|i_riscv_lsu_return_trap);
   assign w_go    = i_riscv_lsu_valid & ~w_kill;

   // Ambiguous atomic selects suppress the access entirely.
   assign w_multi = (i_riscv_lsu_lr[1] & i_riscv_lsu_sc[1]) |
                    (i_riscv_lsu_lr[1] & i_riscv_lsu_amo)   |
                    (i_riscv_lsu_sc[1] & i_riscv_lsu_amo);

   assign w_op_rd  = ~w_multi & i_riscv_lsu_dcache_rden;
   assign w_op_wr  = ~w_multi & ~i_riscv_lsu_dcache_rden & i_riscv_lsu_dcache_wren;
   assign w_op_lr  = ~w_multi & ~i_riscv_lsu_dcache_rden & ~i_riscv_lsu_dcache_wren & i_riscv_lsu_lr[1];
   assign w_op_sc  = ~w_multi & ~i_riscv_lsu_dcache_rden & ~i_riscv_lsu_dcache_wren & i_riscv_lsu_sc[1];
   assign w_op_amo = ~w_multi & ~i_riscv_lsu_dcache_rden & ~i_riscv_lsu_dcache_wren & i_riscv_lsu_amo;

   assign w_addr = (i_riscv_lsu_dcache_rden | i_riscv_lsu_dcache_wren) ?
                   i_riscv_lsu_alu_result : i_riscv_lsu_address;

   for (genvar k = 0; k < NUM_HARTS; k++) begin : g_mtimecmp
      assign w_cmp_hit[k] = (w_addr == CLINT + XLEN'('h4000) + XLEN'(8 * k));
   end

   always_comb begin
      w_regsel = '0;
      if (w_addr == CLINT + XLEN'('hBFF8)) begin
         w_regsel = RSEL_W'(1);
      end
      for (int k = 0; k < NUM_HARTS; k++) begin
         if (w_cmp_hit[k]) begin
            w_regsel = RSEL_W'(k + 2);
         end
      end
   end

   assign w_timer_hit = (w_regsel != '0);

   assign w_sc_ok   = w_go & w_op_sc & rsv_valid_q &
                      (i_riscv_lsu_address[XLEN-1:RSV_GRAN_LOG2] == rsv_gran_q) &
                      (rsv_word_q == i_riscv_lsu_sc[0]);
   assign w_sc_fail = w_go & w_op_sc & ~w_sc_ok;

   assign w_idle_rd = w_go & ~w_timer_hit & (w_op_rd | w_op_lr | w_op_amo);
   assign w_idle_wr = w_go & ~w_timer_hit & (w_op_wr | w_op_amo | (w_op_sc & w_sc_ok));

   assign w_store_hit = w_go & (w_op_wr | w_op_amo) &
                        (w_addr[XLEN-1:RSV_GRAN_LOG2] == rsv_gran_q);

   always_comb begin
      rsv_valid_d = rsv_valid_q;
      rsv_word_d  = rsv_word_q;
      rsv_gran_d  = rsv_gran_q;
      rsv_cnt_d   = rsv_cnt_q;
      if ((state_q == ST_IDLE) && !i_riscv_lsu_globstall) begin
         if (w_kill) begin
            rsv_valid_d = 1'b0;
            rsv_cnt_d   = '0;
         end else if (w_go & w_op_lr) begin
            rsv_valid_d = 1'b1;
            rsv_word_d  = i_riscv_lsu_lr[0];
            rsv_gran_d  = i_riscv_lsu_address[XLEN-1:RSV_GRAN_LOG2];
            rsv_cnt_d   = CNT_W'(RSV_TIMEOUT);
         end else if ((w_go & w_op_sc) | w_store_hit) begin
            rsv_valid_d = 1'b0;
            rsv_cnt_d   = '0;
         end else if (rsv_valid_q) begin
            rsv_cnt_d = rsv_cnt_q - CNT_W'(1);
            if (rsv_cnt_q == CNT_W'(1)) begin
               rsv_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
      if (i_riscv_lsu_rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         rsv_valid_q <= 1'b0;
         rsv_word_q  <= 1'b0;
         rsv_gran_q  <= '0;
         rsv_cnt_q   <= '0;
      end else begin
         rsv_valid_q <= rsv_valid_d;
         rsv_word_q  <= rsv_word_d;
         rsv_gran_q  <= rsv_gran_d;
         rsv_cnt_q   <= rsv_cnt_d;
         case (state_q)
            ST_IDLE: begin
               if ((w_idle_rd | w_idle_wr) & ~i_riscv_lsu_dcache_ack) begin
                  state_q <= ST_WAIT;
                  addr_q  <= w_addr;
                  rd_q    <= w_idle_rd;
                  wr_q    <= w_idle_wr;
               end
            end
            ST_WAIT: begin
               if (i_riscv_lsu_dcache_ack) begin
                  state_q <= ST_IDLE;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Reset gates the combinational strobes so they drop without a clock edge.
   always_comb begin
      o_riscv_lsu_dcache_rden  = 1'b0;
      o_riscv_lsu_dcache_wren  = 1'b0;
      o_riscv_lsu_phy_address  = '0;
      o_riscv_lsu_sc_rdvalue   = '0;
      o_riscv_lsu_timer_rden   = 1'b0;
      o_riscv_lsu_timer_wren   = 1'b0;
      o_riscv_lsu_timer_regsel = '0;
      o_riscv_lsu_busy         = 1'b0;
      o_riscv_lsu_reserv_valid = 1'b0;
      if (!i_riscv_lsu_rst) begin
         o_riscv_lsu_reserv_valid = rsv_valid_q;
         if (state_q == ST_WAIT) begin
            o_riscv_lsu_dcache_rden = rd_q;
            o_riscv_lsu_dcache_wren = wr_q;
            o_riscv_lsu_phy_address = addr_q;
            o_riscv_lsu_busy        = 1'b1;
         end else begin
            o_riscv_lsu_dcache_rden = w_idle_rd;
            o_riscv_lsu_dcache_wren = w_idle_wr;
            o_riscv_lsu_phy_address = (w_idle_rd | w_idle_wr) ? w_addr : '0;
            o_riscv_lsu_busy        = (w_idle_rd | w_idle_wr) & ~i_riscv_lsu_dcache_ack;
            o_riscv_lsu_sc_rdvalue  = {{(XLEN-1){1'b0}}, w_sc_fail};
            if (w_go & w_timer_hit & (w_op_rd | w_op_wr)) begin
               o_riscv_lsu_timer_rden   = w_op_rd;
               o_riscv_lsu_timer_wren   = w_op_wr;
               o_riscv_lsu_timer_regsel = w_regsel;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_riscv_lsu_v2                                              |
// | Description : Directed bench for riscv_lsu_v2 with a behavioural model.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_riscv_lsu_v2;

   localparam int          NH     = 2;
   localparam int          TMO    = 4;
   localparam int          G      = 3;
   localparam int          RSEL_W = $clog2(NH + 1) + 1;
   localparam logic [63:0] CLINT  = 64'h2000000;

   localparam logic [2:0] K_NONE = 3'd0, K_RD = 3'd1, K_WR = 3'd2,
                          K_LR = 3'd3, K_SC = 3'd4, K_AMO = 3'd5;

   logic              clk = 1'b0;
   logic              rst, gstall, valid, amo, rden, wren, trap, ack;
   logic [63:0]       addr, alu;
   logic [1:0]        lr, sc, ret;
   logic              o_rden, o_wren, o_trd, o_twr, o_busy, o_rv;
   logic [63:0]       o_addr, o_scr;
   logic [RSEL_W-1:0] o_sel;

   int n_vec = 0;
   int n_err = 0;

   riscv_lsu_v2 #(
      .XLEN(64), .CLINT(CLINT), .NUM_HARTS(NH),
      .RSV_GRAN_LOG2(G), .RSV_TIMEOUT(TMO), .CNT_W(8)
   ) dut (
      .i_riscv_lsu_clk(clk),              .i_riscv_lsu_rst(rst),
      .i_riscv_lsu_globstall(gstall),     .i_riscv_lsu_valid(valid),
      .i_riscv_lsu_address(addr),         .i_riscv_lsu_alu_result(alu),
      .i_riscv_lsu_lr(lr),                .i_riscv_lsu_sc(sc),
      .i_riscv_lsu_amo(amo),              .i_riscv_lsu_dcache_rden(rden),
      .i_riscv_lsu_dcache_wren(wren),     .i_riscv_lsu_goto_trap(trap),
      .i_riscv_lsu_return_trap(ret),      .i_riscv_lsu_dcache_ack(ack),
      .o_riscv_lsu_dcache_rden(o_rden),   .o_riscv_lsu_dcache_wren(o_wren),
      .o_riscv_lsu_phy_address(o_addr),   .o_riscv_lsu_sc_rdvalue(o_scr),
      .o_riscv_lsu_timer_rden(o_trd),     .o_riscv_lsu_timer_wren(o_twr),
      .o_riscv_lsu_timer_regsel(o_sel),   .o_riscv_lsu_busy(o_busy),
      .o_riscv_lsu_reserv_valid(o_rv)
   );

   always #5 clk = ~clk;

   // Model state: outstanding request and the reservation as plain values.
   logic        m_wait, m_prd, m_pwr, m_rv, m_rword;
   logic [63:0] m_paddr, m_rgran;
   int          m_life;

   typedef struct packed {
      logic        kill, go, scok, rd, wr, trd, twr, busy, scr;
      logic [2:0]  kind;
      logic [2:0]  sel;
      logic [63:0] ea;
      logic [63:0] addr;
   } exp_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [2:0] tsel(input logic [63:0] a);
      logic [63:0] base;
      base = CLINT + 64'h4000;
      if (a == CLINT + 64'hBFF8) return 3'd1;
      if (a >= base && a < base + 64'(8 * NH) && a[2:0] == 3'b000)
         return 3'(2 + ((a - base) >> 3));
      return 3'd0;
   endfunction

   function automatic exp_t eval();
      exp_t e;
      int   nsel;
      e      = '0;
      e.kill = trap | (ret != 2'b00);
      e.go   = valid & !e.kill;
      nsel   = int'(lr[1]) + int'(sc[1]) + int'(amo);
      if (nsel > 1)    e.kind = K_NONE;
      else if (rden)   e.kind = K_RD;
      else if (wren)   e.kind = K_WR;
      else if (lr[1])  e.kind = K_LR;
      else if (sc[1])  e.kind = K_SC;
      else if (amo)    e.kind = K_AMO;
      else             e.kind = K_NONE;
      e.ea   = (rden || wren) ? alu : addr;
      e.scok = e.go && e.kind == K_SC && m_rv && (addr >> G) == m_rgran && m_rword == sc[0];
      if (e.go && tsel(e.ea) != 3'd0) begin
         e.trd = (e.kind == K_RD);
         e.twr = (e.kind == K_WR);
         if (e.trd || e.twr) e.sel = tsel(e.ea);
      end else if (e.go) begin
         e.rd = (e.kind == K_RD) || (e.kind == K_LR) || (e.kind == K_AMO);
         e.wr = (e.kind == K_WR) || (e.kind == K_AMO) || (e.kind == K_SC && e.scok);
      end
      e.addr = (e.rd || e.wr) ? e.ea : 64'd0;
      e.busy = (e.rd || e.wr) && !ack;
      e.scr  = e.go && e.kind == K_SC && !e.scok;
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin
      exp_t e;
      if (rst) begin
         m_wait <= 1'b0; m_prd <= 1'b0; m_pwr <= 1'b0; m_paddr <= '0;
         m_rv <= 1'b0; m_rword <= 1'b0; m_rgran <= '0; m_life <= 0;
      end else if (m_wait) begin
         if (ack) m_wait <= 1'b0;
      end else begin
         e = eval();
         if ((e.rd || e.wr) && !ack) begin
            m_wait <= 1'b1; m_paddr <= e.ea; m_prd <= e.rd; m_pwr <= e.wr;
         end
         if (!gstall) begin
            if (e.kill) m_rv <= 1'b0;
            else if (e.go && e.kind == K_LR) begin
               m_rv <= 1'b1; m_rgran <= addr >> G; m_rword <= lr[0]; m_life <= TMO;
            end else if (e.go && e.kind == K_SC) m_rv <= 1'b0;
            else if (e.go && (e.kind == K_WR || e.kind == K_AMO) && (e.ea >> G) == m_rgran)
               m_rv <= 1'b0;
            else if (m_rv) begin
               m_life <= m_life - 1;
               if (m_life == 1) m_rv <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      e = eval();
      if (rst) e = '0;
      else if (m_wait) begin
         e = '0; e.rd = m_prd; e.wr = m_pwr; e.addr = m_paddr; e.busy = 1'b1;
      end
      chk("rden",   64'(o_rden), 64'(e.rd));
      chk("wren",   64'(o_wren), 64'(e.wr));
      chk("addr",   o_addr,      e.addr);
      chk("sc_rd",  o_scr,       64'(e.scr));
      chk("t_rden", 64'(o_trd),  64'(e.trd));
      chk("t_wren", 64'(o_twr),  64'(e.twr));
      chk("regsel", 64'(o_sel),  64'(e.sel));
      chk("busy",   64'(o_busy), 64'(e.busy));
      chk("rsv",    64'(o_rv),   64'(rst ? 1'b0 : m_rv));
   end

   task automatic idle_in();
      gstall = 0; valid = 0; amo = 0; rden = 0; wren = 0; trap = 0; ack = 0;
      addr = '0; alu = '0; lr = 2'b00; sc = 2'b00; ret = 2'b00;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      @(negedge clk);
      chk("L_reset_busy", 64'(o_busy), 64'd0);
      chk("L_reset_rsv",  64'(o_rv),   64'd0);
      chk("L_reset_rden", 64'(o_rden), 64'd0);
      tick(); rst = 1'b0; tick();

      // LR.d / SC.d success
      valid = 1; lr = 2'b10; addr = 64'h1000; ack = 1; tick();
      idle_in(); tick(); tick(); tick();
      valid = 1; sc = 2'b10; addr = 64'h1000; ack = 1;
      @(negedge clk);
      chk("L_sc_ok_wren", 64'(o_wren), 64'd1);
      chk("L_sc_ok_val",  o_scr,       64'd0);
      chk("L_sc_ok_addr", o_addr,      64'h1000);
      tick(); idle_in();
      @(negedge clk);
      chk("L_sc_ok_rsv", 64'(o_rv), 64'd0);
      tick();

      // Store snoop in the reserved granule
      valid = 1; lr = 2'b11; addr = 64'h1000; ack = 1; tick();
      idle_in(); valid = 1; wren = 1; alu = 64'h1004; ack = 1; tick();
      idle_in(); valid = 1; sc = 2'b11; addr = 64'h1000; ack = 1;
      @(negedge clk);
      chk("L_snoop_scr",  o_scr,       64'd1);
      chk("L_snoop_wren", 64'(o_wren), 64'd0);
      tick(); idle_in(); tick();

      // Reservation timeout
      valid = 1; lr = 2'b10; addr = 64'h2000; ack = 1; tick();
      idle_in(); tick(); tick(); tick();
      @(negedge clk);
      chk("L_tmo_rsv3", 64'(o_rv), 64'd1);
      tick();
      @(negedge clk);
      chk("L_tmo_rsv4", 64'(o_rv), 64'd0);
      valid = 1; sc = 2'b10; addr = 64'h2000; ack = 1;
      @(negedge clk);
      chk("L_tmo_scr", o_scr, 64'd1);
      tick(); idle_in(); tick();

      // Load with ack delayed; new inputs ignored while waiting
      valid = 1; rden = 1; alu = 64'h3000; ack = 0;
      @(negedge clk);
      chk("L_ld_busy0", 64'(o_busy), 64'd1);
      tick();
      idle_in(); valid = 1; wren = 1; alu = 64'hDEAD0; gstall = 1;
      @(negedge clk);
      chk("L_ld_addr1", o_addr,      64'h3000);
      chk("L_ld_rden1", 64'(o_rden), 64'd1);
      tick();
      ack = 1;
      @(negedge clk);
      chk("L_ld_busy2", 64'(o_busy), 64'd1);
      tick(); idle_in();
      @(negedge clk);
      chk("L_ld_idle", 64'(o_busy), 64'd0);
      tick();

      // CLINT accesses
      valid = 1; wren = 1; alu = CLINT + 64'h4008;
      @(negedge clk);
      chk("L_tmr_wren", 64'(o_twr),  64'd1);
      chk("L_tmr_sel",  64'(o_sel),  64'd3);
      chk("L_tmr_dwr",  64'(o_wren), 64'd0);
      chk("L_tmr_busy", 64'(o_busy), 64'd0);
      tick();
      idle_in(); valid = 1; rden = 1; alu = CLINT + 64'hBFF8;
      @(negedge clk);
      chk("L_mtime_sel", 64'(o_sel), 64'd1);
      tick();

      // Multi-hot, globstall, word-size mismatch, AMO
      idle_in(); valid = 1; lr = 2'b10; sc = 2'b10; addr = 64'h4000; ack = 1; tick();
      idle_in(); valid = 1; gstall = 1; lr = 2'b10; addr = 64'h4000; ack = 1; tick();
      idle_in(); valid = 1; lr = 2'b10; addr = 64'h4000; ack = 1; tick();
      idle_in(); valid = 1; sc = 2'b11; addr = 64'h4000; ack = 1; tick();
      idle_in(); valid = 1; lr = 2'b11; addr = 64'h4100; ack = 1; tick();
      idle_in(); valid = 1; amo = 1; addr = 64'h4104; ack = 0; tick();
      ack = 1; tick(); idle_in(); tick();
      valid = 1; ret = 2'b01; wren = 1; alu = 64'h5000; tick(); idle_in(); tick();

      // Reset while waiting
      valid = 1; rden = 1; alu = 64'h6000; ack = 0; tick();
      rst = 1'b1; #1;
      chk("L_rstw_rden", 64'(o_rden), 64'd0);
      chk("L_rstw_busy", 64'(o_busy), 64'd0);
      chk("L_rstw_addr", o_addr,      64'd0);
      tick(); idle_in(); rst = 1'b0; tick();

      // LR together with a trap
      valid = 1; lr = 2'b10; addr = 64'h7000; trap = 1; ack = 1; tick();
      idle_in();
      @(negedge clk);
      chk("L_lrtrap_rsv", 64'(o_rv), 64'd0);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
